// File: rtl/mod_signal_fmt_if.sv
// Bus bundle for mod_signal_fmt: pacing/format controls, the source ROM read
// port and the formatted-sample output toward the modulator multiplier.
// The master side drives controls and source data; the slave is the formatter.
interface mod_signal_fmt_if #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned OUT_W = 9,
    parameter int unsigned NCH   = 2,
    parameter int unsigned CH_W  = 1,
    parameter int unsigned DIV_W = 16
);
    logic [DIV_W-1:0]        rate_div;
    logic [CH_W-1:0]         ch_sel;
    logic [1:0]              mode;
    logic [2:0]              shift;
    logic [NCH*IN_W-1:0]     src_data;
    logic                    src_rd;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;

    modport master (
        output rate_div,
        output ch_sel,
        output mode,
        output shift,
        output src_data,
        input  src_rd,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  rate_div,
        input  ch_sel,
        input  mode,
        input  shift,
        input  src_data,
        output src_rd,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/mod_signal_fmt.sv
// Modulating-signal formatter: paces NCH source ROM reads with a rate
// divider, picks one channel, converts unsigned / offset-binary / two's
// complement samples to a signed OUT_W word, applies a left-shift gain and
// emits the result with a one-cycle valid strobe.
// Optional feature macro: MOD_FMT_SAT_EN (saturate instead of wrapping after
// the gain shift).
// Pipeline: tick -> src_rd (C) -> read pending (C+1, ROM latency) ->
// capture (C+2, convert/shift combinationally) -> dout (C+3).
module mod_signal_fmt #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned OUT_W = 9,
    parameter int unsigned NCH   = 2,
    parameter int unsigned CH_W  = 1,
    parameter int unsigned DIV_W = 16
) (
    input logic             clk,
    input logic             rst,
    mod_signal_fmt_if.slave bus
);

    // Mask that flips the sample MSB (offset-binary to two's complement).
    localparam logic [IN_W-1:0] MsbMask = IN_W'(1) << (IN_W - 1);

`ifdef MOD_FMT_SAT_EN
    // Seven spare bits hold any shift of 0..7 without loss before clamping.
    localparam int unsigned WideW = OUT_W + 7;
    localparam logic signed [WideW-1:0] SatMax =
        {{(WideW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [WideW-1:0] SatMin =
        {{(WideW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
`endif

    // Rate divider and shadowed controls.
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             src_rd_q;
    logic [CH_W-1:0]  sh_ch_q;
    logic [1:0]       sh_mode_q;
    logic [2:0]       sh_shift_q;

    // Read-pending stage: the ROM presents data one cycle after src_rd.
    logic             pend_vld_q;
    logic [CH_W-1:0]  pend_ch_q;
    logic [1:0]       pend_mode_q;
    logic [2:0]       pend_shift_q;
    logic [IN_W-1:0]  samp;

    // Capture stage.
    logic             cap_vld_q;
    logic [IN_W-1:0]  cap_x_q;
    logic [1:0]       cap_mode_q;
    logic [2:0]       cap_shift_q;

    // Convert / gain / reduce.
    logic [IN_W-1:0]         x_ob;
    logic signed [OUT_W-1:0] conv;
    logic signed [OUT_W-1:0] res;
`ifdef MOD_FMT_SAT_EN
    logic signed [WideW-1:0] wide;
`endif

    // Output register.
    logic                    dout_vld_q;
    logic signed [OUT_W-1:0] dout_q;

    // Tick on >= so a rate_div reduction below the current count wraps at once.
    always_comb begin
        tick  = (cnt_q >= bus.rate_div);
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end

    // Divider count, read strobe and control shadows latched on each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            src_rd_q   <= 1'b0;
            sh_ch_q    <= '0;
            sh_mode_q  <= '0;
            sh_shift_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            src_rd_q <= tick;
            if (tick) begin
                sh_ch_q    <= bus.ch_sel;
                sh_mode_q  <= bus.mode;
                sh_shift_q <= bus.shift;
            end
        end
    end

    // Carry each sample's controls along so back-to-back ticks cannot clobber them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q   <= 1'b0;
            pend_ch_q    <= '0;
            pend_mode_q  <= '0;
            pend_shift_q <= '0;
        end else begin
            pend_vld_q <= src_rd_q;
            if (src_rd_q) begin
                pend_ch_q    <= sh_ch_q;
                pend_mode_q  <= sh_mode_q;
                pend_shift_q <= sh_shift_q;
            end
        end
    end

    // Channel mux; selects with no matching channel fall back to channel 0.
    always_comb begin
        samp = bus.src_data[IN_W-1:0];
        for (int unsigned k = 1; k < NCH; k++) begin
            if (pend_ch_q == CH_W'(k)) begin
                samp = bus.src_data[k*IN_W +: IN_W];
            end
        end
    end

    // Capture the source word in the cycle the ROM presents it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q   <= 1'b0;
            cap_x_q     <= '0;
            cap_mode_q  <= '0;
            cap_shift_q <= '0;
        end else begin
            cap_vld_q <= pend_vld_q;
            if (pend_vld_q) begin
                cap_x_q     <= samp;
                cap_mode_q  <= pend_mode_q;
                cap_shift_q <= pend_shift_q;
            end
        end
    end

    // Code conversion, left-shift gain and reduction to OUT_W.
    always_comb begin
        x_ob = cap_x_q ^ MsbMask;
        case (cap_mode_q)
            2'd1:    conv = {{(OUT_W - IN_W){x_ob[IN_W-1]}}, x_ob};
            2'd2:    conv = {{(OUT_W - IN_W){cap_x_q[IN_W-1]}}, cap_x_q};
            default: conv = {{(OUT_W - IN_W){1'b0}}, cap_x_q};
        endcase
`ifdef MOD_FMT_SAT_EN
        wide = {{7{conv[OUT_W-1]}}, conv} <<< cap_shift_q;
        if (wide > SatMax) begin
            res = SatMax[OUT_W-1:0];
        end else if (wide < SatMin) begin
            res = SatMin[OUT_W-1:0];
        end else begin
            res = wide[OUT_W-1:0];
        end
`else
        // Shifting at OUT_W directly keeps exactly the low bits (wrap-around).
        res = conv <<< cap_shift_q;
`endif
    end

    // Output register: dout holds between samples, valid pulses per sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            dout_vld_q <= cap_vld_q;
            if (cap_vld_q) begin
                dout_q <= res;
            end
        end
    end

    assign bus.src_rd     = src_rd_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_vld_q;

endmodule

// File: tb/tb_mod_signal_fmt.sv
// Self-checking bench for mod_signal_fmt (IN_W=7, OUT_W=9, NCH=2) plus a
// second NCH=1 instance for out-of-range channel selects. A cycle-indexed
// reference model predicts src_rd, dout_valid and dout from the pacing and
// formatting rules; directed checks cover the listed corner values.
// Build with MOD_FMT_SAT_EN defined to exercise the saturating variant.
module tb_mod_signal_fmt;

    localparam int IW   = 7;
    localparam int OW   = 9;
    localparam int Nch  = 2;
    localparam int MaxC = 4096;

`ifdef MOD_FMT_SAT_EN
    localparam logic [OW-1:0] ExpM1S3 = 9'h0FF;
`else
    localparam logic [OW-1:0] ExpM1S3 = 9'h1F8;
`endif

    logic clk;
    logic rst;

    mod_signal_fmt_if #(.IN_W(IW), .OUT_W(OW), .NCH(Nch), .CH_W(1), .DIV_W(16)) bus ();
    mod_signal_fmt_if #(.IN_W(IW), .OUT_W(OW), .NCH(1), .CH_W(1), .DIV_W(16)) bus1 ();

    mod_signal_fmt #(.IN_W(IW), .OUT_W(OW), .NCH(Nch), .CH_W(1), .DIV_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mod_signal_fmt #(.IN_W(IW), .OUT_W(OW), .NCH(1), .CH_W(1), .DIV_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [OW-1:0] dout_u;
    logic [OW-1:0] dout1_u;
    assign dout_u  = bus.dout;
    assign dout1_u = bus1.dout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cap_edge;
        int ch;
        int mode;
        int shift;
    } rec_t;

    rec_t          pend_q[$];
    int            m_cnt = 0;
    bit            e_rd   [MaxC];
    bit            e_vld  [MaxC];
    bit            e_zero [MaxC];
    logic [OW-1:0] e_val  [MaxC];
    logic [OW-1:0] held = '0;

    function automatic logic [OW-1:0] fmt(input int x, input int mode, input int sh);
        int v;
        int half;
        half = 1 << (IW - 1);
        case (mode)
            1:       v = x - half;
            2:       v = (x >= half) ? x - 2 * half : x;
            default: v = x;
        endcase
        v = v * (1 << sh);
`ifdef MOD_FMT_SAT_EN
        if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
        if (v < -(1 << (OW - 1)))    v = -(1 << (OW - 1));
`endif
        return v[OW-1:0];
    endfunction

    // Called at every rising edge; n is the cycle that edge closes.
    task automatic model_edge();
        int   n;
        int   x;
        rec_t r;
        n = cyc;
        if (rst) begin
            m_cnt = 0;
            pend_q.delete();
            for (int i = n + 1; i <= n + 6; i++) begin
                if (i < MaxC) begin
                    e_rd[i]  = 1'b0;
                    e_vld[i] = 1'b0;
                end
            end
            if (n + 1 < MaxC) e_zero[n+1] = 1'b1;
        end else begin
            while (pend_q.size() > 0 && pend_q[0].cap_edge == n) begin
                r = pend_q.pop_front();
                x = int'(bus.src_data[r.ch*IW +: IW]);
                if (n + 2 < MaxC) begin
                    e_vld[n+2] = 1'b1;
                    e_val[n+2] = fmt(x, r.mode, r.shift);
                end
            end
            if (m_cnt >= int'(bus.rate_div)) begin
                if (n + 1 < MaxC) e_rd[n+1] = 1'b1;
                r.cap_edge = n + 2;
                r.ch       = (int'(bus.ch_sel) >= Nch) ? 0 : int'(bus.ch_sel);
                r.mode     = int'(bus.mode);
                r.shift    = int'(bus.shift);
                pend_q.push_back(r);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        cyc = n + 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Advance to mid-cycle and compare all outputs against the model.
    task automatic step();
        @(negedge clk);
        if (cyc >= 1 && cyc < MaxC) begin
            if (e_zero[cyc]) held = '0;
            else if (e_vld[cyc]) held = e_val[cyc];
            check_eq("src_rd", 32'(bus.src_rd), 32'(e_rd[cyc]));
            check_eq("dout_valid", 32'(bus.dout_valid), 32'(e_vld[cyc]));
            check_eq("dout", 32'(dout_u), 32'(held));
        end
    endtask

    // Bounded wait for src_rd (want_vld=0) or dout_valid (want_vld=1).
    task automatic wait_for(input bit want_vld, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((want_vld ? bus.dout_valid : bus.src_rd) == 1'b1) begin
                at = cyc;
                break;
            end
        end
        check_eq(want_vld ? "wait_vld" : "wait_rd", 32'(at >= 0), 32'd1);
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [2:0]    shift;
        logic [IW-1:0] x;
        logic [OW-1:0] exp;
    } vec_t;

    initial begin
        int   c0;
        int   rd_at;
        int   v_at;
        int   s0;
        int   s1;
        vec_t vecs[5];
        bit   rst_vld_exp[4];

        rst           = 1'b1;
        bus.rate_div  = '0;
        bus.ch_sel    = '0;
        bus.mode      = '0;
        bus.shift     = '0;
        bus.src_data  = {7'h00, 7'h7F};
        bus1.rate_div = '0;
        bus1.ch_sel   = 1'b1;
        bus1.mode     = '0;
        bus1.shift    = '0;
        bus1.src_data = 7'h15;

        repeat (3) step();
        check_eq("rst_src_rd", 32'(bus.src_rd), 32'd0);
        check_eq("rst_dout", 32'(dout_u), 32'd0);
        check_eq("rst_dout_valid", 32'(bus.dout_valid), 32'd0);

        // Mode 0, rate 0, ch0 = 7F: first src_rd one cycle after release.
        rst = 1'b0;
        c0  = cyc;
        wait_for(1'b0, 10, rd_at);
        check_eq("first_rd_cycle", 32'(rd_at - c0), 32'd1);
        wait_for(1'b1, 10, v_at);
        check_eq("first_vld_latency", 32'(v_at - rd_at), 32'd3);
        check_eq("m0_7f", 32'(dout_u), 32'h07F);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("vld_every_cycle", 32'(bus.dout_valid), 32'd1);
        end

        // Conversion / gain corner values.
        vecs[0] = '{2'd1, 3'd0, 7'h00, 9'h1C0};
        vecs[1] = '{2'd1, 3'd0, 7'h7F, 9'h03F};
        vecs[2] = '{2'd1, 3'd0, 7'h40, 9'h000};
        vecs[3] = '{2'd1, 3'd3, 7'h7F, ExpM1S3};
        vecs[4] = '{2'd2, 3'd2, 7'h40, 9'h100};
        for (int i = 0; i < 5; i++) begin
            bus.mode     = vecs[i].mode;
            bus.shift    = vecs[i].shift;
            bus.src_data = {7'h00, vecs[i].x};
            repeat (6) step();
            check_eq("mode_vec", 32'(dout_u), 32'(vecs[i].exp));
        end

        // rate_div = 4: period 5, latency 3, then cut to 1 while cnt = 3.
        bus.mode     = 2'd0;
        bus.shift    = 3'd0;
        bus.src_data = {7'h00, 7'h2A};
        bus.rate_div = 16'd4;
        wait_for(1'b0, 12, s0);
        wait_for(1'b0, 12, s1);
        check_eq("rd_period", 32'(s1 - s0), 32'd5);
        wait_for(1'b1, 12, v_at);
        check_eq("vld_after_rd", 32'(v_at - s1), 32'd3);
        check_eq("m0_2a", 32'(dout_u), 32'h02A);
        bus.rate_div = 16'd1;
        step();
        check_eq("rd_after_reduce", 32'(bus.src_rd), 32'd1);

        // Live ch_sel change between ticks only affects the next sample.
        bus.rate_div = 16'd4;
        bus.ch_sel   = 1'b0;
        bus.src_data = {7'h22, 7'h11};
        wait_for(1'b0, 12, s0);
        wait_for(1'b0, 12, s1);
        step();
        bus.ch_sel = 1'b1;
        wait_for(1'b1, 12, v_at);
        check_eq("ch_in_flight", 32'(dout_u), 32'h011);
        wait_for(1'b1, 12, v_at);
        check_eq("ch_switched", 32'(dout_u), 32'h022);

        // Reset with samples in flight at rate 0.
        bus.rate_div = 16'd0;
        bus.ch_sel   = 1'b0;
        bus.src_data = {7'h00, 7'h33};
        repeat (6) step();
        rst = 1'b1;
        step();
        check_eq("rst_flush_dout", 32'(dout_u), 32'd0);
        check_eq("rst_flush_vld", 32'(bus.dout_valid), 32'd0);
        check_eq("rst_flush_rd", 32'(bus.src_rd), 32'd0);
        rst = 1'b0;
        rst_vld_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) check_eq("rd_after_rst", 32'(bus.src_rd), 32'd1);
            check_eq("post_rst_vld", 32'(bus.dout_valid), 32'(rst_vld_exp[i]));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step();
            bus.src_data = $urandom;
            if ($urandom_range(0, 19) == 0) bus.rate_div = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0)  bus.ch_sel   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)  bus.mode     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)  bus.shift    = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 79) == 0);
        end
        rst = 1'b0;
        repeat (8) step();

        // NCH=1 instance: ch_sel=1 falls back to channel 0.
        check_eq("nch1_dout", 32'(dout1_u), 32'h015);
        check_eq("nch1_vld", 32'(bus1.dout_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
